// File: rtl/ctrl_mst.sv
// ctrl_mst: master-side initiator for the RS-485 control line.
// Sends a 4-byte 8N1 command frame (A5, cmd, addr, data). For reads it then
// waits for a 2-byte reply (5A, data) within a timeout window.
module ctrl_mst #(
  parameter int BIT_US     = 8,
  parameter int TIMEOUT_US = 1000
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       pluse_us,
  input  logic       req,
  input  logic       req_wr,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic [1:0] err,
  output logic       tx_ctrl,
  input  logic       rx_ctrl
);

  localparam int US_W   = $clog2(BIT_US);
  localparam int TO_RAW = $clog2(TIMEOUT_US + 1);
  localparam int TO_W   = (TO_RAW > 16) ? TO_RAW : 16;

  localparam logic [US_W-1:0] BIT_LAST  = US_W'(BIT_US - 1);
  localparam logic [US_W-1:0] HALF_LAST = US_W'(BIT_US / 2 - 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_US - 1);

  localparam logic [7:0] SYNC_CMD   = 8'hA5;
  localparam logic [7:0] SYNC_REPLY = 8'h5A;
  localparam logic [7:0] CMD_WR     = 8'h01;
  localparam logic [7:0] CMD_RD     = 8'h02;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_FRAME   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX,
    S_RX_WAIT,
    S_RX_START,
    S_RX_BYTE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [US_W-1:0]   usCnt_q, usCnt_d;
  logic [3:0]        bitIdx_q, bitIdx_d;
  logic [1:0]        byteIdx_q, byteIdx_d;
  logic              txStarted_q, txStarted_d;
  logic              txLine_q, txLine_d;
  logic              wr_q, wr_d;
  logic [7:0]        addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        rxShift_q, rxShift_d;
  logic              rxByteCnt_q, rxByteCnt_d;
  logic [TO_W-1:0]   toCnt_q, toCnt_d;
  logic [7:0]        rdata_q, rdata_d;
  logic [1:0]        err_q, err_d;
  logic              rxMeta_q, rxSync_q, rxPrev_q;

  logic [7:0]        curByte;
  logic              fallEdge;
  logic              inRx;

  // Byte of the command frame selected by the byte index.
  function automatic logic [7:0] frameByte(input logic [1:0] idx, input logic wr,
                                           input logic [7:0] addr, input logic [7:0] wdata);
    logic [7:0] b;
    case (idx)
      2'd0:    b = SYNC_CMD;
      2'd1:    b = wr ? CMD_WR : CMD_RD;
      2'd2:    b = addr;
      default: b = wr ? wdata : 8'h00;
    endcase
    return b;
  endfunction

  // Line level for bit position idx of an 8N1 character (0 = start, 9 = stop).
  function automatic logic frameBit(input logic [7:0] b, input logic [3:0] idx);
    logic [7:0] sh;
    logic       v;
    v  = 1'b1;
    sh = 8'h00;
    if (idx == 4'd0) begin
      v = 1'b0;
    end else if (idx <= 4'd8) begin
      sh = b >> (idx - 4'd1);
      v  = sh[0];
    end
    return v;
  endfunction

  // Bit index increment that parks at all-ones instead of wrapping.
  function automatic logic [3:0] satInc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  assign curByte  = frameByte(byteIdx_q, wr_q, addr_q, wdata_q);
  assign fallEdge = rxPrev_q & ~rxSync_q;
  assign inRx     = (state_q == S_RX_WAIT) || (state_q == S_RX_START) || (state_q == S_RX_BYTE);

  assign busy    = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done    = (state_q == S_DONE);
  assign rdata   = rdata_q;
  assign err     = err_q;
  assign tx_ctrl = txLine_q;

  // Two-flop synchronizer plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
      rxPrev_q <= 1'b1;
    end else begin
      rxMeta_q <= rx_ctrl;
      rxSync_q <= rxMeta_q;
      rxPrev_q <= rxSync_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      usCnt_q     <= '0;
      bitIdx_q    <= '0;
      byteIdx_q   <= '0;
      txStarted_q <= 1'b0;
      txLine_q    <= 1'b1;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rxShift_q   <= '0;
      rxByteCnt_q <= 1'b0;
      toCnt_q     <= '0;
      rdata_q     <= '0;
      err_q       <= ERR_OK;
    end else begin
      state_q     <= state_d;
      usCnt_q     <= usCnt_d;
      bitIdx_q    <= bitIdx_d;
      byteIdx_q   <= byteIdx_d;
      txStarted_q <= txStarted_d;
      txLine_q    <= txLine_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rxShift_q   <= rxShift_d;
      rxByteCnt_q <= rxByteCnt_d;
      toCnt_q     <= toCnt_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic: transmitter, receiver and reply timeout.
  always_comb begin
    state_d     = state_q;
    usCnt_d     = usCnt_q;
    bitIdx_d    = bitIdx_q;
    byteIdx_d   = byteIdx_q;
    txStarted_d = txStarted_q;
    txLine_d    = txLine_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rxShift_d   = rxShift_q;
    rxByteCnt_d = rxByteCnt_q;
    toCnt_d     = toCnt_q;
    rdata_d     = rdata_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        txLine_d = 1'b1;
        if (req) begin
          state_d     = S_TX;
          wr_d        = req_wr;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          txStarted_d = 1'b0;
          usCnt_d     = '0;
          bitIdx_d    = '0;
          byteIdx_d   = '0;
        end
      end

      S_TX: begin
        if (pluse_us) begin
          if (!txStarted_q) begin
            txStarted_d = 1'b1;
            usCnt_d     = '0;
            bitIdx_d    = '0;
            txLine_d    = 1'b0;
          end else if (usCnt_q != BIT_LAST) begin
            usCnt_d = usCnt_q + 1'b1;
          end else begin
            usCnt_d = '0;
            if (bitIdx_q == 4'd9) begin
              if (byteIdx_q == 2'd3) begin
                txLine_d    = 1'b1;
                txStarted_d = 1'b0;
                if (wr_q) begin
                  state_d = S_DONE;
                  err_d   = ERR_OK;
                end else begin
                  state_d     = S_RX_WAIT;
                  toCnt_d     = '0;
                  rxByteCnt_d = 1'b0;
                end
              end else begin
                byteIdx_d = byteIdx_q + 2'd1;
                bitIdx_d  = '0;
                txLine_d  = 1'b0;
              end
            end else begin
              bitIdx_d = satInc(bitIdx_q);
              txLine_d = frameBit(curByte, satInc(bitIdx_q));
            end
          end
        end
      end

      S_RX_WAIT: begin
        if (fallEdge) begin
          state_d = S_RX_START;
          usCnt_d = '0;
        end
      end

      S_RX_START: begin
        if (pluse_us) begin
          if (usCnt_q != HALF_LAST) begin
            usCnt_d = usCnt_q + 1'b1;
          end else begin
            usCnt_d = '0;
            if (!rxSync_q) begin
              state_d  = S_RX_BYTE;
              bitIdx_d = '0;
            end else begin
              state_d = S_RX_WAIT;
            end
          end
        end
      end

      S_RX_BYTE: begin
        if (pluse_us) begin
          if (usCnt_q != BIT_LAST) begin
            usCnt_d = usCnt_q + 1'b1;
          end else begin
            usCnt_d = '0;
            if (bitIdx_q != 4'd8) begin
              rxShift_d = {rxSync_q, rxShift_q[7:1]};
              bitIdx_d  = satInc(bitIdx_q);
            end else if (!rxSync_q) begin
              state_d = S_DONE;
              err_d   = ERR_FRAME;
            end else if (!rxByteCnt_q) begin
              if (rxShift_q != SYNC_REPLY) begin
                state_d = S_DONE;
                err_d   = ERR_FRAME;
              end else begin
                rxByteCnt_d = 1'b1;
                state_d     = S_RX_WAIT;
              end
            end else begin
              rdata_d = rxShift_q;
              err_d   = ERR_OK;
              state_d = S_DONE;
            end
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (inRx && pluse_us) begin
      if ((toCnt_q == TO_LAST) && (state_d != S_DONE)) begin
        state_d = S_DONE;
        err_d   = ERR_TIMEOUT;
      end else begin
        toCnt_d = toCnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ctrl_mst.sv
// tb_ctrl_mst: directed bench for ctrl_mst with hand-computed frames and replies.
module tb_ctrl_mst;

  localparam int BIT_US     = 8;
  localparam int TIMEOUT_US = 1000;

  logic       clk_sys   = 1'b0;
  logic       rst_n     = 1'b0;
  logic       pluse_us  = 1'b0;
  logic       req       = 1'b0;
  logic       req_wr    = 1'b0;
  logic [7:0] req_addr  = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic [1:0] err;
  logic       tx_ctrl;
  logic       rx_ctrl   = 1'b1;

  int         checkCount = 0;
  int         errorCount = 0;
  int         doneCnt    = 0;
  int         prevDone;
  logic [1:0] errAtDone  = 2'b00;
  logic [7:0] rdataAtDone = 8'h00;

  ctrl_mst #(.BIT_US(BIT_US), .TIMEOUT_US(TIMEOUT_US)) dut (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .pluse_us  (pluse_us),
    .req       (req),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .err       (err),
    .tx_ctrl   (tx_ctrl),
    .rx_ctrl   (rx_ctrl)
  );

  // 100 MHz clock.
  always #5 clk_sys = ~clk_sys;

  // One-cycle microsecond strobe every 4 clocks, changed just after the edge.
  initial begin
    forever begin
      repeat (3) @(posedge clk_sys);
      #1 pluse_us = 1'b1;
      @(posedge clk_sys);
      #1 pluse_us = 1'b0;
    end
  end

  // Capture status at every done pulse.
  always @(negedge clk_sys) begin
    if (done === 1'b1) begin
      doneCnt     = doneCnt + 1;
      errAtDone   = err;
      rdataAtDone = rdata;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount = checkCount + 1;
    if (observed !== expected) begin
      errorCount = errorCount + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Returns at the falling clock edge just before the n-th following strobe is consumed.
  task automatic waitUs(input int n);
    repeat (n) begin
      @(negedge clk_sys);
      while (!pluse_us) @(negedge clk_sys);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [7:0] addr, input logic [7:0] wdata);
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req       = 1'b1;
    @(negedge clk_sys);
    req       = 1'b0;
  endtask

  // Samples each transmitted bit in its middle and compares whole characters.
  task automatic checkFrame(input logic [31:0] frame);
    int         waitCyc;
    logic [9:0] got;
    logic [7:0] expByte;
    logic [31:0] f;
    waitCyc = 0;
    got     = '0;
    while (tx_ctrl !== 1'b0 && waitCyc < 40) begin
      @(negedge clk_sys);
      waitCyc++;
    end
    if (tx_ctrl !== 1'b0) begin
      checkOutput("txStartSeen", 32'(tx_ctrl), 32'h0);
      return;
    end
    f = frame;
    for (int i = 0; i < 4; i++) begin
      expByte = f[31:24];
      f       = f << 8;
      for (int k = 0; k < 10; k++) begin
        waitUs((i == 0 && k == 0) ? BIT_US / 2 : BIT_US);
        got[k] = tx_ctrl;
      end
      checkOutput($sformatf("txByte%0d", i), 32'(got), 32'({1'b1, expByte, 1'b0}));
    end
    waitUs(BIT_US / 2);
  endtask

  // Called just before the strobe that ends the last stop bit of a write.
  task automatic checkWriteDone();
    checkOutput("wrDoneEarly", 32'(done), 32'h0);
    checkOutput("wrBusyHeld", 32'(busy), 32'h1);
    @(negedge clk_sys);
    checkOutput("wrDone", 32'(done), 32'h1);
    checkOutput("wrBusyFall", 32'(busy), 32'h0);
    checkOutput("wrErr", 32'(err), 32'h0);
    @(negedge clk_sys);
    checkOutput("wrDonePulse", 32'(done), 32'h0);
  endtask

  task automatic sendByte(input logic [7:0] b, input logic stopBit);
    rx_ctrl = 1'b0;
    waitUs(BIT_US);
    for (int i = 0; i < 8; i++) begin
      rx_ctrl = b[i];
      waitUs(BIT_US);
    end
    rx_ctrl = stopBit;
    waitUs(BIT_US);
    rx_ctrl = 1'b1;
  endtask

  task automatic finishSim();
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  endtask

  initial begin
    #3000000;
    errorCount = errorCount + 1;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    finishSim();
  end

  initial begin
    repeat (3) @(negedge clk_sys);
    checkOutput("rstTx", 32'(tx_ctrl), 32'h1);
    checkOutput("rstBusy", 32'(busy), 32'h0);
    checkOutput("rstDone", 32'(done), 32'h0);
    checkOutput("rstRdata", 32'(rdata), 32'h0);
    checkOutput("rstErr", 32'(err), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    $display("[TB] write 0x12 <= 0x34");
    applyStimulus(1'b1, 8'h12, 8'h34);
    checkOutput("wrBusyRise", 32'(busy), 32'h1);
    checkFrame(32'hA5011234);
    checkWriteDone();

    $display("[TB] read 0x40 with reply 5A C3, extra req during TX");
    applyStimulus(1'b0, 8'h40, 8'h99);
    fork
      checkFrame(32'hA5024000);
      begin
        waitUs(100);
        applyStimulus(1'b1, 8'hFF, 8'hEE);
      end
    join
    waitUs(1);
    checkOutput("rdWaitBusy", 32'(busy), 32'h1);
    waitUs(49);
    prevDone = doneCnt;
    sendByte(8'h5A, 1'b1);
    sendByte(8'hC3, 1'b1);
    waitUs(2);
    checkOutput("rdDoneCnt", 32'(doneCnt), 32'(prevDone + 1));
    checkOutput("rdErr", 32'(errAtDone), 32'h0);
    checkOutput("rdData", 32'(rdataAtDone), 32'hC3);
    checkOutput("rdBusyIdle", 32'(busy), 32'h0);

    $display("[TB] read with no reply");
    applyStimulus(1'b0, 8'h41, 8'h00);
    checkFrame(32'hA5024100);
    waitUs(TIMEOUT_US);
    checkOutput("toDoneEarly", 32'(done), 32'h0);
    @(negedge clk_sys);
    checkOutput("toDone", 32'(done), 32'h1);
    checkOutput("toErr", 32'(err), 32'h1);
    checkOutput("toRdata", 32'(rdata), 32'hC3);
    waitUs(2);

    $display("[TB] read with bad sync 55");
    applyStimulus(1'b0, 8'h42, 8'h00);
    checkFrame(32'hA5024200);
    waitUs(50);
    prevDone = doneCnt;
    sendByte(8'h55, 1'b1);
    waitUs(2);
    checkOutput("syncDoneCnt", 32'(doneCnt), 32'(prevDone + 1));
    checkOutput("syncErr", 32'(errAtDone), 32'h2);
    checkOutput("syncRdata", 32'(rdataAtDone), 32'hC3);
    checkOutput("syncBusy", 32'(busy), 32'h0);

    $display("[TB] read with glitch before reply 5A 77");
    applyStimulus(1'b0, 8'h43, 8'h00);
    checkFrame(32'hA5024300);
    waitUs(20);
    prevDone = doneCnt;
    rx_ctrl = 1'b0;
    waitUs(2);
    rx_ctrl = 1'b1;
    waitUs(10);
    checkOutput("glitchNoDone", 32'(doneCnt), 32'(prevDone));
    sendByte(8'h5A, 1'b1);
    sendByte(8'h77, 1'b1);
    waitUs(2);
    checkOutput("glitchDoneCnt", 32'(doneCnt), 32'(prevDone + 1));
    checkOutput("glitchErr", 32'(errAtDone), 32'h0);
    checkOutput("glitchData", 32'(rdataAtDone), 32'h77);

    $display("[TB] read with reply stop bit low");
    applyStimulus(1'b0, 8'h44, 8'h00);
    checkFrame(32'hA5024400);
    waitUs(50);
    prevDone = doneCnt;
    sendByte(8'h5A, 1'b1);
    sendByte(8'hC3, 1'b0);
    waitUs(2);
    checkOutput("stopDoneCnt", 32'(doneCnt), 32'(prevDone + 1));
    checkOutput("stopErr", 32'(errAtDone), 32'h2);
    checkOutput("stopRdata", 32'(rdata), 32'h77);

    $display("[TB] reset during byte 2 of a write");
    applyStimulus(1'b1, 8'h5B, 8'h6C);
    waitUs(190);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstTx", 32'(tx_ctrl), 32'h1);
    checkOutput("midRstBusy", 32'(busy), 32'h0);
    checkOutput("midRstDone", 32'(done), 32'h0);
    checkOutput("midRstErr", 32'(err), 32'h0);
    checkOutput("midRstRdata", 32'(rdata), 32'h0);
    prevDone = doneCnt;
    repeat (5) @(negedge clk_sys);
    rst_n = 1'b1;
    waitUs(20);
    checkOutput("postRstNoDone", 32'(doneCnt), 32'(prevDone));
    checkOutput("postRstTx", 32'(tx_ctrl), 32'h1);
    applyStimulus(1'b1, 8'h21, 8'h43);
    checkFrame(32'hA5012143);
    checkWriteDone();

    finishSim();
  end

endmodule

// File: doc/ctrl_mst.md
# ctrl_mst

Master-side initiator for the RS-485 control line: it turns single register read/write requests from master logic into command frames on `tx_ctrl` and, for reads, collects the slave's reply from `rx_ctrl`. It is the far end of the slave FPGA's `control_top`, which decodes these frames onto its fx bus. The block runs in the `clk_sys` domain and times bits from the shared one-microsecond strobe `pluse_us`.

## Interface
- `BIT_US`, default 8: bit period in `pluse_us` strobes (8 gives 125 kbaud); must be even and ≥ 2.
- `TIMEOUT_US`, default 1000: reply window in `pluse_us` strobes.
- `clk_sys` input 1: system clock; the only clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `pluse_us` input 1: one-cycle strobe every 1 µs.
- `req` input 1: request strobe; sampled only while `busy`=0.
- `req_wr` input 1: 1 = write, 0 = read.
- `req_addr` input 8: register address.
- `req_wdata` input 8: write data; ignored for reads.
- `busy` output 1: transaction in progress.
- `done` output 1: one-cycle pulse at the end of each transaction.
- `rdata` output 8: read data, updated only on a successful read.
- `err` output 2: status, valid with `done` and held until the next `done`. 00 = ok, 01 = timeout, 10 = bad sync byte or framing error.
- `tx_ctrl` output 1: serial line out, idle high.
- `rx_ctrl` input 1: serial line in; asynchronous to `clk_sys`.

## Operation
- Character format: UART 8N1. Start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts `BIT_US` strobes.
- Command frame, 4 bytes:
  - sync 0xA5;
  - cmd: 0x01 for write, 0x02 for read;
  - `req_addr`;
  - data: `req_wdata` for write, 0x00 for read.
- Reply frame, reads only: sync 0x5A, then the data byte. Writes get no reply.
- States:
  - IDLE → TX on `req`. Operands are latched at the same time.
  - TX sends bytes 0–3 back to back, with no idle gap between a stop bit and the next start bit.
  - After byte 3: a write goes to DONE; a read goes to RX_WAIT.
  - RX_WAIT → RX_BYTE on a confirmed start bit.
  - RX_BYTE → RX_WAIT after the first byte, → DONE after the second.
  - DONE lasts one cycle, pulses `done`, then returns to IDLE.
- Receiver:
  - `rx_ctrl` passes through a 2-flop synchronizer.
  - Start detection: a falling edge seen in RX_WAIT starts a count of `BIT_US`/2 strobes. If the line is no longer 0 at that point, it was a glitch: return to RX_WAIT and keep the timeout running.
  - Data and stop bits are then sampled every `BIT_US` strobes.
  - Stop bit sampled as 0 → `err`=10, go to DONE.
  - First byte ≠ 0x5A → `err`=10, go to DONE immediately without waiting for byte 2.
- Timeout:
  - The counter clears at the end of the last TX stop bit and counts `pluse_us` through RX_WAIT and RX_BYTE.
  - Reaching `TIMEOUT_US` → `err`=01, go to DONE. This aborts any partial byte.
- `rdata` loads byte 2 only when `err`=00. On an error `rdata` keeps its old value.
- `rx_ctrl` is ignored outside RX_WAIT and RX_BYTE; this also discards the half-duplex echo during TX.
- `req` while `busy`=1 is dropped. There is no queueing.

## Timing
- Reset values: `tx_ctrl`=1, `busy`=0, `done`=0, `rdata`=0x00, `err`=00, state IDLE, all counters 0.
- Reset mid-transaction: all outputs return to their reset values immediately (asynchronous). No `done` is produced for the aborted transaction.
- `req` sampled high in IDLE → `busy`=1 on the next edge.
- The start bit begins at the first `pluse_us` after that, so up to 1 µs of jitter.
- The frame takes 40·`BIT_US` strobes (320 µs at the default).
- Write: `done` is asserted in the cycle after the final stop-bit period expires; `busy` falls together with `done`.
- Read: `done` is asserted in the cycle after the reply's stop-bit sample, or in the cycle the timeout is reached.
- `pluse_us` and the timeout limit in the same cycle as a valid stop sample: the stop sample wins and the reply completes.
- Counter widths: wide enough for `TIMEOUT_US` without wrap (16 bits at the default). Bit counters saturate in an unreachable state rather than wrap.

## Test plan
- Write `req_addr`=0x12, `req_wdata`=0x34 → `tx_ctrl` carries A5 01 12 34 as 8N1. `done` pulses after 320 µs ±1 µs with `err`=00, and no RX activity is required.
- Read `req_addr`=0x40; the bench replies 5A C3 starting 50 µs after the frame → `tx_ctrl` carries A5 02 40 00; then `rdata`=0xC3 and `err`=00 at `done`.
- Read with no reply → `done` exactly 1000 µs after the last stop bit, `err`=01, `rdata` unchanged.
- Read, bench replies 55 C3 → `done` after the first byte, `err`=10. Read, bench replies 5A C3 with stop bit 0 → `err`=10. In both cases `rdata` unchanged.
- A 2 µs low glitch on `rx_ctrl` in RX_WAIT, then a valid 5A 77 → glitch ignored, `rdata`=0x77, `err`=00.
- `req` pulsed again during TX → ignored, frame unchanged. `rst_n` low mid byte 2 → `tx_ctrl`=1 and `busy`=0 at once; after release, a fresh write completes normally.
